// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_pkg
// Brief    : Shared types, widths and the rotating one-hot pick helper for
//            the TFT SPI arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tft_pkg;

    localparam int TFT_BYTE_W = 8;
    localparam int MAX_REQ_W  = 4;
    localparam int MAX_REQ    = 1 << MAX_REQ_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // First set bit of req scanning upward from start, wrapping at num.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        start,
        input int unsigned        num
    );
        logic [MAX_REQ-1:0]   win;
        logic                 found;
        int unsigned          idx;
        logic [MAX_REQ_W-1:0] sel;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < num) begin
                idx = start + k;
                if (idx >= num) idx = idx - num;
                sel = idx[MAX_REQ_W-1:0];
                if (!found && req[sel]) begin
                    win[sel] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational one-hot picker starting at a given index; start = 0
//            gives plain fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import tft_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_start,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDW-1:0]     o_idx,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_win;

    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = i_req;
        w_win                    = rr_pick(w_req_ext, 32'(i_start), NUM_REQ);
        o_onehot                 = w_win[NUM_REQ-1:0];
        o_any                    = |w_win;
        o_idx                    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) o_idx = IDW'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tft_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tft_spi_arbiter
// Brief    : Registered-grant arbiter sharing one tft_spi byte transmitter
//            among several requesters, with watchdog revocation.
// Revision : 1.0 - initial release
// ============================================================================
module tft_spi_arbiter
    import tft_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ROUND_ROBIN = 0,
    parameter int TIMEOUT     = 4096
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_REQ-1:0]                         req,
    input  logic [TFT_BYTE_W*NUM_REQ-1:0]              req_data,
    input  logic [NUM_REQ-1:0]                         req_dc,
    input  logic [NUM_REQ-1:0]                         req_transmit,
    output logic [NUM_REQ-1:0]                         req_busy,
    output logic [NUM_REQ-1:0]                         grant,
    output logic [TFT_BYTE_W-1:0]                      spi_data,
    output logic                                       spi_dc,
    output logic                                       spi_transmit,
    input  logic                                       spi_busy,
    output logic                                       active,
    output logic                                       timeout_err,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] timeout_id
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_masked, w_mask_set;
    logic [IDW-1:0]     r_ptr, w_ptr_nxt;
    logic [IDW-1:0]     r_tid, w_tid_nxt;
    logic               r_terr, w_terr_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;

    logic [NUM_REQ-1:0] w_win;
    logic [IDW-1:0]     w_win_idx;
    logic               w_win_any;
    logic [IDW-1:0]     w_start;
    logic [IDW-1:0]     w_gidx;
    logic               w_fwd_tx;
    logic               w_own_req;
    logic               w_expire;

    always_comb begin
        w_start = '0;
        if (ROUND_ROBIN != 0) begin
            w_start = (r_ptr == IDW'(NUM_REQ - 1)) ? '0 : r_ptr + IDW'(1);
        end
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .i_req    (req & ~r_masked),
        .i_start  (w_start),
        .o_onehot (w_win),
        .o_idx    (w_win_idx),
        .o_any    (w_win_any)
    );

    // Grant is one-hot only while GRANTED, so an empty grant yields zero outputs.
    always_comb begin
        spi_data = '0;
        spi_dc   = 1'b0;
        w_fwd_tx = 1'b0;
        w_gidx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                spi_data = req_data[i*TFT_BYTE_W +: TFT_BYTE_W];
                spi_dc   = req_dc[i];
                w_fwd_tx = req_transmit[i];
                w_gidx   = IDW'(i);
            end
        end
    end

    assign w_own_req    = |(req & r_grant);
    assign w_expire     = (TIMEOUT != 0) && !w_fwd_tx && !spi_busy
                          && (r_cnt == CW'(TIMEOUT - 1));
    assign spi_transmit = w_fwd_tx & rst;
    assign req_busy     = ~r_grant | {NUM_REQ{spi_busy}};
    assign grant        = r_grant;
    assign active       = (r_state == ST_GRANTED);
    assign timeout_err  = r_terr;
    assign timeout_id   = r_tid;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_tid_nxt   = r_tid;
        w_terr_nxt  = 1'b0;
        w_mask_set  = '0;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_any) begin
                    w_grant_nxt = w_win;
                    w_ptr_nxt   = w_win_idx;
                    w_state_nxt = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                // A dropped request takes precedence over a coincident expiry.
                if (!w_own_req) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_RELEASE;
                end else if (w_expire) begin
                    w_grant_nxt = '0;
                    w_terr_nxt  = 1'b1;
                    w_tid_nxt   = w_gidx;
                    w_mask_set  = r_grant;
                    w_state_nxt = ST_RELEASE;
                end else if (!w_fwd_tx && !spi_busy) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (!spi_busy) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_masked <= '0;
            r_ptr    <= IDW'(NUM_REQ - 1);
            r_tid    <= '0;
            r_terr   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_masked <= (r_masked | w_mask_set) & req;
            r_ptr    <= w_ptr_nxt;
            r_tid    <= w_tid_nxt;
            r_terr   <= w_terr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tft_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_spi_arbiter
// Brief    : Directed self-checking bench for tft_spi_arbiter (fixed priority
//            and round-robin instances sharing one stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_spi_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  req_dc;
    logic [2:0]  req_transmit;
    logic        spi_busy;

    logic [2:0]  req_busy, grant;
    logic [7:0]  spi_data;
    logic        spi_dc, spi_transmit, active, timeout_err;
    logic [1:0]  timeout_id;

    logic [2:0]  rr_req_busy, rr_grant;
    logic [7:0]  rr_spi_data;
    logic        rr_spi_dc, rr_spi_transmit, rr_active, rr_timeout_err;
    logic [1:0]  rr_timeout_id;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    tft_spi_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(0), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_dc       (req_dc),
        .req_transmit (req_transmit),
        .req_busy     (req_busy),
        .grant        (grant),
        .spi_data     (spi_data),
        .spi_dc       (spi_dc),
        .spi_transmit (spi_transmit),
        .spi_busy     (spi_busy),
        .active       (active),
        .timeout_err  (timeout_err),
        .timeout_id   (timeout_id)
    );

    tft_spi_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1), .TIMEOUT(8)) dut_rr (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_dc       (req_dc),
        .req_transmit (req_transmit),
        .req_busy     (rr_req_busy),
        .grant        (rr_grant),
        .spi_data     (rr_spi_data),
        .spi_dc       (rr_spi_dc),
        .spi_transmit (rr_spi_transmit),
        .spi_busy     (spi_busy),
        .active       (rr_active),
        .timeout_err  (rr_timeout_err),
        .timeout_id   (rr_timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; req = '0; req_data = '0; req_dc = '0; req_transmit = '0; spi_busy = 1'b0;
        step(); step(); #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        chk("rst_tid", 32'(timeout_id), 32'h0);
        chk("rst_busy", 32'(req_busy), 32'h7);
        chk("rst_tx", 32'(spi_transmit), 32'h0);
        chk("rst_data", 32'(spi_data), 32'h0);
        rst = 1'b1;
        step();

        // Fixed priority: 1 wins alone, then keeps ownership once 0 joins
        req = 3'b110;
        step(); #1;
        chk("fp_first", 32'(grant), 32'h2);
        chk("fp_active", 32'(active), 32'h1);
        req = 3'b111;
        step(); #1;
        chk("fp_hold", 32'(grant), 32'h2);
        chk("fp_busy_view", 32'(req_busy), 32'h5);
        req_data = 24'h00_3C_00; req_dc = 3'b010; req_transmit = 3'b010; #1;
        chk("fwd_tx", 32'(spi_transmit), 32'h1);
        chk("fwd_data", 32'(spi_data), 32'h3C);
        chk("fwd_dc", 32'(spi_dc), 32'h1);
        step();
        req_transmit = '0; req = 3'b101;
        step(); #1;
        chk("rel_grant", 32'(grant), 32'h0);
        chk("rel_active", 32'(active), 32'h0);
        chk("rel_busy", 32'(req_busy), 32'h7);
        step(); #1;
        chk("idle_grant", 32'(grant), 32'h0);
        step(); #1;
        chk("fp_second", 32'(grant), 32'h1);

        // Isolation: requester 2 strobes while 0 owns
        spi_busy = 1'b1;
        req_data = 24'hA5_00_00; req_dc = 3'b100; req_transmit = 3'b100; #1;
        chk("iso_tx", 32'(spi_transmit), 32'h0);
        chk("iso_data", 32'(spi_data), 32'h0);
        chk("iso_dc", 32'(spi_dc), 32'h0);
        chk("iso_busy", 32'(req_busy), 32'h7);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("iso_tx_hold", 32'(spi_transmit), 32'h0);
            chk("iso_busy2", 32'(req_busy[2]), 32'h1);
        end
        spi_busy = 1'b0; #1;
        chk("iso_owner_busy", 32'(req_busy), 32'h6);

        // Release wait: owner 0 drops while SPI stays busy
        req_transmit = '0; req_dc = '0; spi_busy = 1'b1; req = 3'b110;
        step();
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("rw_grant", 32'(grant), 32'h0);
            chk("rw_active", 32'(active), 32'h0);
            step();
        end
        spi_busy = 1'b0;
        step(); #1;
        chk("rw_idle", 32'(grant), 32'h0);
        step(); #1;
        chk("rw_regrant", 32'(grant), 32'h2);

        // Watchdog: owner 1 sits idle
        for (int i = 0; i < 7; i++) step();
        #1;
        chk("wd_pre_grant", 32'(grant), 32'h2);
        chk("wd_pre_terr", 32'(timeout_err), 32'h0);
        step(); #1;
        chk("wd_terr", 32'(timeout_err), 32'h1);
        chk("wd_tid", 32'(timeout_id), 32'h1);
        chk("wd_grant", 32'(grant), 32'h0);
        step(); #1;
        chk("wd_terr_pulse", 32'(timeout_err), 32'h0);
        chk("wd_tid_held", 32'(timeout_id), 32'h1);
        step(); #1;
        chk("wd_skip_masked", 32'(grant), 32'h4);
        req = 3'b010;
        step(); step(); step(); #1;
        chk("wd_still_masked", 32'(grant), 32'h0);
        req = 3'b000;
        step();
        req = 3'b010;
        step(); #1;
        chk("wd_unmasked", 32'(grant), 32'h2);

        // Reset during a forwarded byte
        req_data = 24'h00_A5_00; req_transmit = 3'b010; #1;
        chk("rs_fwd", 32'(spi_transmit), 32'h1);
        chk("rs_fwd_data", 32'(spi_data), 32'hA5);
        rst = 1'b0;
        step(); #1;
        chk("rs_grant", 32'(grant), 32'h0);
        chk("rs_active", 32'(active), 32'h0);
        chk("rs_tx", 32'(spi_transmit), 32'h0);
        chk("rs_busy", 32'(req_busy), 32'h7);
        rst = 1'b1; req_transmit = '0; req = '0;
        step();

        // Request drop in the same cycle the watchdog would expire
        req = 3'b001;
        step(); #1;
        chk("de_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 7; i++) step();
        req = 3'b000;
        step(); #1;
        chk("de_terr", 32'(timeout_err), 32'h0);
        chk("de_grant_clr", 32'(grant), 32'h0);
        step(); #1;
        chk("de_terr2", 32'(timeout_err), 32'h0);
        req = 3'b001;
        step(); #1;
        chk("de_not_masked", 32'(grant), 32'h1);
        req = '0;
        step(); step();

        // Round-robin instance
        rst = 1'b0;
        step();
        rst = 1'b1; spi_busy = 1'b0; req = 3'b111;
        step();
        for (int r = 0; r < 4; r++) begin
            #1;
            chk("rr_order", 32'(rr_grant), 32'(rr_exp[r]));
            req_transmit = rr_exp[r]; #1;
            chk("rr_fwd", 32'(rr_spi_transmit), 32'h1);
            step(); step();
            req_transmit = '0; req = 3'b111 & ~rr_exp[r];
            step();
            req = 3'b111;
            step(); step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tft_spi_arbiter.md
# tft_spi_arbiter

Shares the single `tft_spi` byte transmitter among several drawing requesters: `tft_init`, `scene_exhibitor`, `player`, and future sprites. It replaces ad-hoc enable priority muxing in the top level with a registered grant. Ownership is held for a whole multi-byte TFT transaction and handed over only on an idle SPI line. A watchdog revokes ownership from a stalled requester.

## Interface
- `NUM_REQ`, default 3: number of requesters; index 0 is highest fixed priority.
- `ROUND_ROBIN`, default 0: 0 selects fixed priority; 1 selects round-robin starting after the last granted index.
- `TIMEOUT`, default 4096: idle-owner cycles before revocation; 0 disables the watchdog.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `req` in `NUM_REQ`: level request for ownership, one bit per requester.
- `req_data` in `8*NUM_REQ`: byte from requester i, on bits `[8i+7:8i]`.
- `req_dc` in `NUM_REQ`: DC bit per requester.
- `req_transmit` in `NUM_REQ`: transmit strobe per requester.
- `req_busy` out `NUM_REQ`: busy view per requester.
- `grant` out `NUM_REQ`: registered one-hot grant, or all zero.
- `spi_data` out 8: byte to `tft_spi`.
- `spi_dc` out 1: DC to `tft_spi`.
- `spi_transmit` out 1: transmit strobe to `tft_spi`.
- `spi_busy` in 1: busy from `tft_spi`.
- `active` out 1: high while in GRANTED.
- `timeout_err` out 1: one-cycle pulse on revocation.
- `timeout_id` out `clog2(NUM_REQ)`: index of the last revoked requester; held until the next revocation.

## Operation
- States are IDLE, GRANTED and RELEASE.
- **IDLE**
  - Eligible set is `req & ~masked`.
  - If the set is non-empty, the winner is chosen by the selected policy; `grant` is loaded and the state goes to GRANTED on the next edge.
  - If the set is empty, the state stays in IDLE.
- **GRANTED**
  - `spi_data`, `spi_dc` and `spi_transmit` are combinational copies of the granted requester's inputs.
  - Strobes from non-granted requesters are ignored.
  - `req_busy[g] = spi_busy` for the granted index g; all other `req_busy` bits are 1.
  - When `req[g]` falls, `grant` is cleared and the state goes to RELEASE. A transmit in that same cycle is still forwarded.
  - When the watchdog expires, `grant` is cleared, `timeout_err` pulses, `timeout_id` is set to g, `masked[g]` is set, and the state goes to RELEASE.
- **RELEASE**
  - `spi_transmit` is 0 and all `req_busy` bits are 1.
  - The state goes to IDLE on the first cycle with `spi_busy` = 0.
- **Watchdog**
  - The counter width is `clog2(TIMEOUT+1)`.
  - It clears on grant, on any forwarded transmit, and on any cycle with `spi_busy` = 1.
  - Otherwise it increments in GRANTED.
  - It expires when it reaches `TIMEOUT`.
- **Masking:** `masked[i]` clears when `req[i]` is low.
- **Round-robin pointer:** updated to the winner index on every grant.
- **Outputs with no grant:** `spi_data` = 0, `spi_dc` = 0, `spi_transmit` = 0.
- **Reset values:** state IDLE, `grant` = 0, `active` = 0, `timeout_err` = 0, `timeout_id` = 0, `masked` = 0, pointer = `NUM_REQ-1` (so index 0 wins first), counter = 0, `req_busy` all 1.

## Timing
- **Request to grant:** `req` high at edge N gives `grant` high after edge N+1, so the owner's first transmit can occur in cycle N+1.
- **Forwarding latency:** 0 cycles from `req_transmit` to `spi_transmit`.
- **Handover:** at least 2 cycles, i.e. one RELEASE cycle plus IDLE arbitration, even if `spi_busy` is already low.
- **Owner drops and re-asserts during RELEASE:** the owner competes normally in IDLE, with no special priority.
- **Request drop vs. watchdog expiry in the same cycle:** the request drop wins; no `timeout_err`, no mask.
- **Reset mid-transaction:** grant drops immediately and the forwarded strobe is 0 from that cycle. `tft_spi` is reset by the same net.
- **`NUM_REQ` = 1:** degenerates to a pass-through with a 1-cycle grant latency.

## Structure
- A shared package `tft_pkg` holds:
  - the state encoding `arb_state_t` (IDLE, GRANTED, RELEASE);
  - the constant `TFT_BYTE_W` = 8, used for data widths;
  - the helper function `rr_pick(req, ptr)`, which returns the one-hot winner.
- One sub-module is natural: `rr_priority_pick`, a combinational one-hot picker. It takes a mask and a start index and is reused for both policies (fixed priority uses start = 0).

## Test plan
- **Fixed priority:** `req`=3'b110 then 3'b111 at the same edge while idle → `grant`=3'b010 first. After req1 drops and `spi_busy`=0, `grant`=3'b001 two cycles later.
- **Round-robin:** `ROUND_ROBIN`=1, all `req` held, each owner drops after 2 bytes → grant order 001, 010, 100, 001.
- **Isolation:** requester 2 strobes `req_transmit` with data 8'hA5 while requester 0 owns → `spi_transmit` stays 0 and `req_busy[2]`=1 throughout.
- **Release wait:** owner drops `req` while `spi_busy`=1 for 16 more cycles → state stays in RELEASE with `grant`=0 for those cycles, then returns to IDLE.
- **Watchdog:** `TIMEOUT`=8, owner 1 idle after its grant → `timeout_err` pulse at cycle 8 with `timeout_id`=1, and no re-grant to requester 1 until its `req` toggles low.
- **Reset:** assert `rst`=0 during a forwarded byte → next cycle `grant`=0, `active`=0, `spi_transmit`=0, `req_busy`=all 1.
